// File: rtl/prl_hard_reset_ctrl_if.sv
// rtl/prl_hard_reset_ctrl_if.sv - PHY reset-send handshake between protocol layer and PHY
interface prl_hard_reset_ctrl_if;
  logic phy_req;
  logic phy_type;
  logic phy_done;

  modport master (output phy_req, output phy_type, input phy_done);
  modport slave  (input phy_req, input phy_type, output phy_done);
endinterface

// File: rtl/prl_hard_reset_ctrl.sv
// rtl/prl_hard_reset_ctrl.sv - USB-PD Hard/Cable Reset controller with timeout, retries and sticky ALERT
module prl_hard_reset_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RETRY_MAX      = 2,
  parameter int CNT_W          = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  cableReset,
  input  logic                  hardReset,
  input  logic                  rd_wr_en,
  input  logic [7:0]            rd_wr_data,
  input  logic [15:0]           alert_clr,
  output logic [7:0]            TRANSMIT,
  output logic [15:0]           ALERT,
  output logic [7:0]            RECEIVE_DETECT,
  output logic [7:0]            RECEIVE_BYTE_COUNT,
  output logic                  PHY_Stop_Attempting_Reset,
  output logic                  busy,
  prl_hard_reset_ctrl_if.master phy
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0]    RMAX_V  = RW'(RETRY_MAX);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_REQ, CONSTRUCT, WAIT_PHY, SUCCESS, FAILURE, REPORT
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [RW-1:0]    r_retry;
  logic             r_ok;
  logic             r_phy_req;
  logic             r_phy_type;
  logic             r_busy;
  logic             r_stop;
  logic [7:0]       r_transmit;
  logic [15:0]      r_alert;
  logic [7:0]       r_rd;
  logic [7:0]       r_rbc;
  logic [15:0]      w_alert_set;

  // Outcome bit lands on the edge leaving REPORT; set beats a same-cycle clear.
  assign w_alert_set = (r_state != REPORT) ? 16'h0000 :
                       (r_ok ? 16'h0040 : 16'h0010);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_retry    <= '0;
      r_ok       <= 1'b0;
      r_phy_req  <= 1'b0;
      r_phy_type <= 1'b0;
      r_busy     <= 1'b0;
      r_stop     <= 1'b0;
      r_transmit <= 8'h00;
      r_alert    <= 16'h0000;
      r_rd       <= 8'h00;
      r_rbc      <= 8'h00;
    end else begin
      r_phy_req <= 1'b0;
      r_alert   <= (r_alert & ~alert_clr) | w_alert_set;
      if (rd_wr_en && !r_busy) r_rd <= rd_wr_data;

      case (r_state)
        IDLE: r_state <= WAIT_REQ;
        WAIT_REQ: begin
          if (cableReset || hardReset) begin
            r_state    <= CONSTRUCT;
            r_phy_type <= cableReset;
            r_retry    <= '0;
            r_stop     <= 1'b0;
            r_phy_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_transmit <= {5'b0, cableReset ? 3'b110 : 3'b101};
            r_rd       <= 8'h00;
            r_rbc      <= 8'h00;
          end
        end
        CONSTRUCT: begin
          r_state <= WAIT_PHY;
          r_timer <= '0;
        end
        WAIT_PHY: begin
          if (phy.phy_done) begin
            r_state <= SUCCESS;
          end else if (r_timer == TO_LAST) begin
            if (r_retry < RMAX_V) begin
              r_state    <= CONSTRUCT;
              r_retry    <= r_retry + 1'b1;
              r_phy_req  <= 1'b1;
              r_transmit <= {5'b0, r_phy_type ? 3'b110 : 3'b101};
              r_rd       <= 8'h00;
              r_rbc      <= 8'h00;
            end else begin
              r_state <= FAILURE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        SUCCESS: begin
          r_ok    <= 1'b1;
          r_state <= REPORT;
        end
        FAILURE: begin
          r_ok    <= 1'b0;
          r_stop  <= 1'b1;
          r_state <= REPORT;
        end
        REPORT: begin
          r_transmit <= 8'h00;
          r_busy     <= 1'b0;
          r_state    <= WAIT_REQ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign TRANSMIT                  = r_transmit;
  assign ALERT                     = r_alert;
  assign RECEIVE_DETECT            = r_rd;
  assign RECEIVE_BYTE_COUNT        = r_rbc;
  assign PHY_Stop_Attempting_Reset = r_stop;
  assign busy                      = r_busy;
  assign phy.phy_req               = r_phy_req;
  assign phy.phy_type              = r_phy_type;

endmodule

// File: doc/prl_hard_reset_ctrl.md
# prl_hard_reset_ctrl

Parametrised USB-PD protocol-layer Hard Reset / Cable Reset controller. It accepts a reset request from policy, programs the TCPC-style TRANSMIT, RECEIVE_DETECT and RECEIVE_BYTE_COUNT registers, and hands the request to the PHY. It then runs a tHardResetComplete timeout with a bounded retry count and reports the outcome through sticky ALERT bits. It sits between the policy engine and the PHY transmit path.

## Interface
- TIMEOUT_CYCLES, 16: tHardResetComplete, in CLK cycles spent in WAIT_PHY per attempt; must be ≥ 2.
- RETRY_MAX, 2: retries after the first attempt; 0 means a single attempt.
- CNT_W, 8: timer width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cableReset  in  1  Cable Reset request, sampled only in WAIT_REQ.
- hardReset  in  1  Hard Reset request, sampled only in WAIT_REQ.
- phy_done  in  1  PHY reports the reset ordered set was sent; sampled only in WAIT_PHY.
- rd_wr_en  in  1  host write strobe for RECEIVE_DETECT.
- rd_wr_data  in  8  host write data for RECEIVE_DETECT.
- alert_clr  in  16  write-1-to-clear mask for ALERT, applied every cycle.
- TRANSMIT  out  8  transmit register; [2:0] is 3'b101 for hard, 3'b110 for cable; [7:3] is always 0.
- ALERT  out  16  sticky; bit 6 TransmitSuccessful, bit 4 TransmitSOPMessageFailed; other bits always 0.
- RECEIVE_DETECT  out  8  receive-enable register.
- RECEIVE_BYTE_COUNT  out  8  receive byte count.
- PHY_Stop_Attempting_Reset  out  1  sticky failure flag.
- phy_req  out  1  one-cycle PHY send request; Moore decode, high exactly while in CONSTRUCT.
- phy_type  out  1  1 = cable reset, 0 = hard reset; valid while busy.
- busy  out  1  high in CONSTRUCT, WAIT_PHY, SUCCESS, FAILURE and REPORT.

## Operation
- States and transitions:
  - IDLE → WAIT_REQ unconditionally.
  - WAIT_REQ → CONSTRUCT when (cableReset | hardReset).
  - CONSTRUCT → WAIT_PHY.
  - WAIT_PHY → SUCCESS on phy_done.
  - WAIT_PHY → CONSTRUCT on timeout while retry_cnt < RETRY_MAX.
  - WAIT_PHY → FAILURE on timeout while retry_cnt == RETRY_MAX.
  - SUCCESS → REPORT. FAILURE → REPORT. REPORT → WAIT_REQ.
- Request acceptance (on the edge leaving WAIT_REQ):
  - phy_type latches cableReset; cable wins if both inputs are high.
  - retry_cnt is cleared to 0.
  - PHY_Stop_Attempting_Reset is cleared.
- Requests arriving in any state other than WAIT_REQ are ignored, not queued.
- On every edge entering CONSTRUCT:
  - TRANSMIT ← {5'b0, phy_type ? 3'b110 : 3'b101}.
  - RECEIVE_DETECT ← 0.
  - RECEIVE_BYTE_COUNT ← 0.
  - A retry re-enters CONSTRUCT and increments retry_cnt, saturating at RETRY_MAX.
- Timer:
  - Cleared to 0 on entry to WAIT_PHY, then increments once per cycle in WAIT_PHY.
  - Timeout is (timer == TIMEOUT_CYCLES−1) && !phy_done.
  - phy_done in the timeout cycle counts as success.
- Outcome:
  - FAILURE sets PHY_Stop_Attempting_Reset to 1; it stays 1 until the next accepted request or reset.
  - The edge leaving REPORT sets ALERT[6] on success, or ALERT[4] on failure.
  - The same edge sets TRANSMIT ← 0.
- ALERT update is ALERT ← (ALERT & ~alert_clr) | set_bits, so a set wins over a clear of the same bit in the same cycle.
- RECEIVE_DETECT host writes:
  - rd_wr_en loads rd_wr_data only when busy == 0.
  - Writes while busy are dropped.
- Reset values:
  - state = IDLE.
  - TRANSMIT, ALERT, RECEIVE_DETECT, RECEIVE_BYTE_COUNT = 0.
  - PHY_Stop_Attempting_Reset, phy_req, phy_type, busy = 0.
  - timer = 0, retry_cnt = 0.
- Reset asserted in any state returns all of the above to their reset values on the next edge. No ALERT is raised for the aborted attempt.

## Timing
- After reset deasserts: one cycle in IDLE, then WAIT_REQ.
- Request high in WAIT_REQ at cycle N:
  - CONSTRUCT at N+1, with phy_req=1 and TRANSMIT valid.
  - WAIT_PHY from N+2, with timer=0.
- phy_done at WAIT_PHY timer=k:
  - SUCCESS at the next cycle, then REPORT.
  - ALERT[6] visible 3 cycles after the phy_done cycle, with the FSM back in WAIT_REQ.
- A timeout attempt spends exactly TIMEOUT_CYCLES cycles in WAIT_PHY.
- Full failure spans (RETRY_MAX+1)·(TIMEOUT_CYCLES+1) cycles from the first CONSTRUCT to entry into FAILURE.
- PHY_Stop_Attempting_Reset rises on the edge leaving FAILURE.
- All outputs are registered or decoded from the state register only; there is no input-to-output combinational path.

## Test plan
- Hard reset success:
  - Stimulus: hardReset=1 one cycle in WAIT_REQ; phy_done at timer=3.
  - Response: TRANSMIT=8'h05 during the attempt; one phy_req pulse; ALERT=16'h0040; TRANSMIT=0 afterwards; PHY_Stop_Attempting_Reset=0.
- Simultaneous cableReset and hardReset:
  - Response: phy_type=1; TRANSMIT=8'h06; RECEIVE_DETECT and RECEIVE_BYTE_COUNT = 0 while busy.
- Timeout then retry success (TIMEOUT_CYCLES=8, RETRY_MAX=2):
  - Stimulus: no phy_done on the first attempt; phy_done at timer=2 of the second attempt.
  - Response: two phy_req pulses 9 cycles apart; ALERT[6]=1; ALERT[4]=0.
- Exhausted retries:
  - Stimulus: phy_done never asserted.
  - Response: three phy_req pulses; ALERT=16'h0010; PHY_Stop_Attempting_Reset=1 until the next accepted request clears it.
- Same-cycle set and clear:
  - Stimulus: alert_clr=16'h0040 in the cycle the ALERT[6] set lands.
  - Response: ALERT[6] remains 1; a clear on the following cycle drops it to 0.
- Reset mid-WAIT_PHY, plus busy write and ignored request:
  - Stimulus: reset during WAIT_PHY; rd_wr_en with rd_wr_data=8'h21 while busy; a hardReset during SUCCESS.
  - Response: all outputs return to reset values with no ALERT raised; the busy write is dropped and RECEIVE_DETECT stays 0; the hardReset during SUCCESS produces no second attempt.
